// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin byte arbiter in front of uart_send; optional frame lock via UART_ARB_LOCK_EN
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 3,
  parameter int BUSY_TIMEOUT = 64
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_lock,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 uart_en,
  output logic [7:0]           uart_din,
  input  logic                 uart_tx_busy,
  output logic [2:0]           grant_id,
  output logic                 tx_err
);

  localparam int              CNT_W    = (BUSY_TIMEOUT > 2) ? $clog2(BUSY_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BUSY_TIMEOUT - 1);
  localparam logic [3:0]      NREQ     = 4'(NUM_REQ);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  state_t             state, state_d;
  logic [2:0]         ptr, ptr_d;
  logic [CNT_W-1:0]   cnt, cnt_d;
  logic               err_d;
  logic [7:0]         din_d;
  logic [2:0]         gid_d;
  logic [NUM_REQ-1:0] ready_d;
  logic [2:0]         start;
  logic [2:0]         idx;
  logic [2:0]         win;
  logic               found;

`ifdef UART_ARB_LOCK_EN
  logic lock_q, lock_d;
`else
  wire unused_lock = ^req_lock;
`endif

  // (a + b) mod NUM_REQ; both operands are already below NUM_REQ so one subtract suffices
  function automatic logic [2:0] add_mod(input logic [2:0] a, input logic [2:0] b);
    logic [3:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= NREQ) s = s - NREQ;
    return s[2:0];
  endfunction

  function automatic logic bit_at(input logic [NUM_REQ-1:0] v, input logic [2:0] i);
    logic r;
    r = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (3'(k) == i) r = v[k];
    end
    return r;
  endfunction

  function automatic logic [7:0] byte_at(input logic [8*NUM_REQ-1:0] d, input logic [2:0] i);
    logic [7:0] r;
    r = 8'h00;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (3'(k) == i) r = d[8*k +: 8];
    end
    return r;
  endfunction

  // State, pointer, timeout counter and all registered outputs
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state     <= IDLE;
      ptr       <= 3'd0;
      cnt       <= '0;
      tx_err    <= 1'b0;
      uart_din  <= 8'h00;
      grant_id  <= 3'd0;
      req_ready <= '0;
`ifdef UART_ARB_LOCK_EN
      lock_q    <= 1'b0;
`endif
    end else begin
      state     <= state_d;
      ptr       <= ptr_d;
      cnt       <= cnt_d;
      tx_err    <= err_d;
      uart_din  <= din_d;
      grant_id  <= gid_d;
      req_ready <= ready_d;
`ifdef UART_ARB_LOCK_EN
      lock_q    <= lock_d;
`endif
    end
  end

  // Arbitration search, launch pulse, busy tracking and pointer update
  always_comb begin
    state_d = state;
    ptr_d   = ptr;
    cnt_d   = cnt;
    err_d   = tx_err;
    din_d   = uart_din;
    gid_d   = grant_id;
    ready_d = '0;
    uart_en = 1'b0;
    start   = ptr;
    idx     = 3'd0;
    win     = 3'd0;
    found   = 1'b0;
`ifdef UART_ARB_LOCK_EN
    lock_d  = lock_q;
`endif
    unique case (state)
      IDLE: begin
`ifdef UART_ARB_LOCK_EN
        // A held lock whose owner has nothing to send falls back to plain round-robin
        if (lock_q && !bit_at(req_valid, ptr)) begin
          start  = add_mod(ptr, 3'd1);
          ptr_d  = start;
          lock_d = 1'b0;
        end
`endif
        for (int k = 0; k < NUM_REQ; k++) begin
          idx = add_mod(start, 3'(k));
          if (!found && bit_at(req_valid, idx)) begin
            found = 1'b1;
            win   = idx;
          end
        end
        if (found) begin
          din_d = byte_at(req_data, win);
          gid_d = win;
          for (int k = 0; k < NUM_REQ; k++) begin
            ready_d[k] = (3'(k) == win);
          end
          state_d = LAUNCH;
`ifdef UART_ARB_LOCK_EN
          lock_d  = 1'b0;
`endif
        end
      end
      LAUNCH: begin
        uart_en = 1'b1;
        cnt_d   = '0;
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (uart_tx_busy) begin
          state_d = WAIT_DONE;
        end else if (cnt == CNT_LAST) begin
          err_d   = 1'b1;
          state_d = IDLE;
          ptr_d   = add_mod(grant_id, 3'd1);
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      WAIT_DONE: begin
        if (!uart_tx_busy) begin
          state_d = IDLE;
          ptr_d   = add_mod(grant_id, 3'd1);
`ifdef UART_ARB_LOCK_EN
          if (bit_at(req_lock, grant_id)) begin
            ptr_d  = grant_id;
            lock_d = 1'b1;
          end
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - directed self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;

  localparam int BUSY_LEN = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  req_valid = '0;
  logic [23:0] req_data = '0;
  logic [2:0]  req_lock = '0;
  logic [2:0]  req_ready;
  logic        uart_en;
  logic [7:0]  uart_din;
  logic        uart_tx_busy = 1'b0;
  logic [2:0]  grant_id;
  logic        tx_err;

  int tests = 0;
  int fails = 0;

  // transmitter model state
  int         busy_cnt = 0;
  logic [7:0] cap = 8'h00;
  bit         dead = 1'b0;
  int         en_count = 0;
  int         en_busy = 0;
  int         din_bad = 0;
  logic [7:0] rx_q[$];

  uart_tx_arbiter #(.NUM_REQ(3), .BUSY_TIMEOUT(64)) dut (
    .sys_clk      (clk),
    .sys_rst      (rst),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_lock     (req_lock),
    .req_ready    (req_ready),
    .uart_en      (uart_en),
    .uart_din     (uart_din),
    .uart_tx_busy (uart_tx_busy),
    .grant_id     (grant_id),
    .tx_err       (tx_err)
  );

  always #5 clk = ~clk;

  // uart_send stand-in: busy rises the cycle after uart_en and stays high BUSY_LEN cycles
  always @(posedge clk) begin
    if (busy_cnt > 0) begin
      if (uart_en) en_busy <= en_busy + 1;
      if (uart_din !== cap) din_bad <= din_bad + 1;
      busy_cnt <= busy_cnt - 1;
      if (busy_cnt == 1) begin
        uart_tx_busy <= 1'b0;
        rx_q.push_back(cap);
      end
    end else if (uart_en && !dead) begin
      cap          <= uart_din;
      uart_tx_busy <= 1'b1;
      busy_cnt     <= BUSY_LEN;
      en_count     <= en_count + 1;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_grant(input string tag, output int lat);
    lat = 0;
    do begin
      tick();
      lat++;
    end while (req_ready == 3'b000 && lat < 400);
    if (req_ready == 3'b000) check({tag, " grant timeout"}, 32'(req_ready != 3'b000), 32'd1);
  endtask

  task automatic wait_rx(input string tag, input int n);
    int t;
    t = 0;
    while (rx_q.size() < n && t < 400) begin
      tick();
      t++;
    end
    check({tag, " rx count"}, 32'(rx_q.size()), 32'(n));
  endtask

  task automatic wait_line_idle();
    int t;
    t = 0;
    while (uart_tx_busy && t < 400) begin
      tick();
      t++;
    end
    check("line idle", 32'(uart_tx_busy), 32'd0);
    repeat (3) tick();
  endtask

  initial begin
    int lat;
    int base;
    int en0;
    int dbad0;
    int n;
    int n2;
    int ngr;
    bit busy_ready;
    logic [7:0] exp_b[$];
    logic [2:0] exp_g[$];

    // reset values
    rst = 1'b1;
    tick();
    tick();
    check("rst uart_en", 32'(uart_en), 32'd0);
    check("rst uart_din", 32'(uart_din), 32'd0);
    check("rst req_ready", 32'(req_ready), 32'd0);
    check("rst grant_id", 32'(grant_id), 32'd0);
    check("rst tx_err", 32'(tx_err), 32'd0);
    rst = 1'b0;
    tick();

    // single byte from requester 0
    base = rx_q.size();
    en0 = en_count;
    req_data[7:0] = 8'h55;
    req_valid = 3'b001;
    tick();
    check("single ready", 32'(req_ready), 32'b001);
    check("single uart_en", 32'(uart_en), 32'd1);
    check("single din", 32'(uart_din), 32'h55);
    check("single gid", 32'(grant_id), 32'd0);
    req_valid = 3'b000;
    tick();
    check("single en drop", 32'(uart_en), 32'd0);
    check("single ready drop", 32'(req_ready), 32'd0);
    wait_rx("single", base + 1);
    check("single rx byte", 32'(rx_q[base]), 32'h55);
    check("single en count", 32'(en_count - en0), 32'd1);
    wait_line_idle();

    // round-robin with all three valid, from a fresh pointer
    rst = 1'b1;
    tick();
    rst = 1'b0;
    base = rx_q.size();
    req_data = {8'h02, 8'h01, 8'h00};
    req_valid = 3'b111;
    for (int i = 0; i < 6; i++) begin
      wait_grant("rr", lat);
      check("rr gid", 32'(grant_id), 32'(i % 3));
      check("rr din", 32'(uart_din), 32'(i % 3));
      if (i == 5) req_valid = 3'b000;
    end
    wait_rx("rr", base + 6);
    for (int i = 0; i < 6; i++) begin
      check("rr rx order", 32'(rx_q[base + i]), 32'(i % 3));
    end
    wait_line_idle();

    // back-pressure: requester 1 waits out a byte in flight
    base = rx_q.size();
    req_data[7:0] = 8'hAA;
    req_valid = 3'b001;
    wait_grant("bp first", lat);
    check("bp first gid", 32'(grant_id), 32'd0);
    req_valid = 3'b000;
    n = 0;
    while (!uart_tx_busy && n < 50) begin
      tick();
      n++;
    end
    tick();
    tick();
    req_data[15:8] = 8'h11;
    req_valid = 3'b010;
    busy_ready = 1'b0;
    n = 0;
    while (uart_tx_busy && n < 100) begin
      if (req_ready != 3'b000) busy_ready = 1'b1;
      tick();
      n++;
    end
    check("bp no ready while busy", 32'(busy_ready), 32'd0);
    wait_grant("bp second", lat);
    check("bp latency after busy fall", 32'(lat), 32'd2);
    check("bp second ready", 32'(req_ready), 32'b010);
    req_valid = 3'b000;
    wait_rx("bp", base + 2);
    check("bp rx0", 32'(rx_q[base]), 32'hAA);
    check("bp rx1", 32'(rx_q[base + 1]), 32'h11);
    check("bp no en while busy", 32'(en_busy), 32'd0);
    wait_line_idle();

    // timeout: transmitter never raises busy
    dead = 1'b1;
    req_data[23:16] = 8'h77;
    req_valid = 3'b100;
    wait_grant("to", lat);
    check("to gid", 32'(grant_id), 32'd2);
    req_valid = 3'b000;
    n = 0;
    while (!tx_err && n < 200) begin
      tick();
      n++;
    end
    check("to cycles to tx_err", 32'(n), 32'd65);
    dead = 1'b0;
    base = rx_q.size();
    req_data[7:0] = 8'h5A;
    req_valid = 3'b001;
    wait_grant("to next", lat);
    check("to next gid", 32'(grant_id), 32'd0);
    req_valid = 3'b000;
    wait_rx("to next", base + 1);
    check("to next rx", 32'(rx_q[base]), 32'h5A);
    check("to err sticky", 32'(tx_err), 32'd1);
    check("din stable in busy", 32'(din_bad), 32'd0);
    wait_line_idle();

    // reset while in WAIT_DONE
    req_data[15:8] = 8'h3C;
    req_valid = 3'b010;
    wait_grant("mr", lat);
    check("mr gid", 32'(grant_id), 32'd1);
    req_valid = 3'b000;
    n = 0;
    while (!uart_tx_busy && n < 50) begin
      tick();
      n++;
    end
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mr uart_en", 32'(uart_en), 32'd0);
    check("mr uart_din", 32'(uart_din), 32'd0);
    check("mr req_ready", 32'(req_ready), 32'd0);
    check("mr grant_id", 32'(grant_id), 32'd0);
    check("mr tx_err", 32'(tx_err), 32'd0);
    wait_line_idle();
    base = rx_q.size();
    dbad0 = din_bad;
    req_data = {8'h12, 8'h11, 8'h10};
    req_valid = 3'b111;
    wait_grant("mr ptr", lat);
    check("mr ptr back to 0", 32'(grant_id), 32'd0);
    check("mr ptr din", 32'(uart_din), 32'h10);
    req_valid = 3'b000;
    wait_rx("mr", base + 1);
    wait_line_idle();

    // frame lock: requester 2 sends A0..A2 while requester 0 stays valid
`ifdef UART_ARB_LOCK_EN
    ngr = 4;
    exp_b = '{8'hA0, 8'hA1, 8'hA2, 8'hC0};
    exp_g = '{3'd2, 3'd2, 3'd2, 3'd0};
`else
    ngr = 5;
    exp_b = '{8'hA0, 8'hC0, 8'hA1, 8'hC0, 8'hA2};
    exp_g = '{3'd2, 3'd0, 3'd2, 3'd0, 3'd2};
`endif
    base = rx_q.size();
    req_data = {8'hA0, 8'h00, 8'hC0};
    req_lock = 3'b100;
    req_valid = 3'b101;
    n2 = 0;
    for (int g = 0; g < ngr; g++) begin
      wait_grant("lock", lat);
      check("lock gid", 32'(grant_id), 32'(exp_g[g]));
      check("lock din", 32'(uart_din), 32'(exp_b[g]));
      if (req_ready[2]) begin
        n2++;
        if (n2 == 1) req_data[23:16] = 8'hA1;
        if (n2 == 2) req_data[23:16] = 8'hA2;
        if (n2 == 3) begin
          req_valid[2] = 1'b0;
          req_lock[2] = 1'b0;
        end
      end
    end
    req_valid = 3'b000;
    req_lock = 3'b000;
    wait_rx("lock", base + ngr);
    for (int g = 0; g < ngr; g++) begin
      check("lock rx order", 32'(rx_q[base + g]), 32'(exp_b[g]));
    end
    check("lock din stable", 32'(din_bad - dbad0), 32'd0);
    check("lock no en while busy", 32'(en_busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single uart_send transmitter between NUM_REQ byte-producing requesters, e.g. the CPU MMIO UART port, the loader echo path and the debug dumper.
- Round-robin grant per byte, with an optional multi-byte frame lock.
- Drives uart_send's uart_en/uart_din and tracks uart_tx_busy to decide when the transmitter is free again.
- Sits inside top, between the requesters and uart_send.

Parameters:
- NUM_REQ, 3, number of requesters (2..8).
- BUSY_TIMEOUT, 64, sys_clk cycles to wait for uart_tx_busy to rise after launch before aborting.

Ports:
- sys_clk  in  1  system clock.
- sys_rst  in  1  synchronous reset, active-high.
- req_valid  in  NUM_REQ  requester i has a byte to send.
- req_data  in  8*NUM_REQ  byte of requester i at bits [8i+7:8i].
- req_lock  in  NUM_REQ  keep grant after this byte (used only with the feature enabled).
- req_ready  out  NUM_REQ  one-cycle accept pulse to requester i.
- uart_en  out  1  launch pulse to uart_send.
- uart_din  out  8  byte to uart_send, held stable from launch to completion.
- uart_tx_busy  in  1  busy flag from uart_send.
- grant_id  out  3  index of the current/last granted requester.
- tx_err  out  1  sticky timeout flag, cleared only by reset.

Behaviour:
- Reset values: uart_en=0, uart_din=0, req_ready=0, grant_id=0, tx_err=0, state=IDLE, round-robin pointer=0, timeout counter=0.
- Reset is sampled every cycle. Reset mid-transfer returns to IDLE immediately; the uart_send line state is not this block's concern.

State machine:
- IDLE:
  - Requester search starts at pointer and wraps modulo NUM_REQ; the first i with req_valid[i]=1 wins.
  - Winner actions, same cycle: latch req_data[i] into uart_din; set grant_id=i; pulse req_ready[i]=1 for exactly one cycle; go to LAUNCH.
  - No valid requester: stay in IDLE with all outputs quiet.
- LAUNCH: uart_en=1 for exactly this one cycle; clear timeout counter; go to WAIT_BUSY.
- WAIT_BUSY:
  - uart_tx_busy=1: go to WAIT_DONE.
  - Otherwise the counter increments each cycle. When it reaches BUSY_TIMEOUT-1 with busy still low: set tx_err=1, go to IDLE, pointer=grant_id+1 (mod NUM_REQ).
- WAIT_DONE:
  - Stay while uart_tx_busy=1.
  - On the first cycle busy=0, go to IDLE and set pointer=grant_id+1 (mod NUM_REQ).
  - No time limit in this state.

Handshake and fairness rules:
- A requester must hold req_valid/req_data stable until it sees req_ready. It may drop valid at any time before ready, without penalty.
- Minimum accept latency: req_valid rising to req_ready takes 1 cycle if IDLE.
- Byte-to-byte spacing for back-to-back traffic: one IDLE cycle after busy falls.
- Several requesters valid together: only one is granted per byte. The pointer guarantees each valid requester is served within NUM_REQ bytes.
- uart_din changes only in IDLE on a grant.
- The pointer wraps from NUM_REQ-1 to 0.
- grant_id width is fixed at 3; the upper bits are 0 when NUM_REQ<8.

Optional Feature:
- Macro: UART_ARB_LOCK_EN.
- Enabled:
  - If req_lock[grant_id]=1 when WAIT_DONE exits, the pointer is set to grant_id rather than grant_id+1. That requester wins the next IDLE arbitration if it is valid, so multi-byte frames go out unbroken.
  - If the locked requester is not valid in that IDLE cycle, the lock is released and normal round-robin from grant_id+1 resumes.
  - A timeout always releases the lock.
- Disabled: req_lock is ignored and the pointer always advances to grant_id+1.

Test Plan:
- Single byte:
  - Stimulus: after reset, req_valid=3'b001, req_data[7:0]=8'h55.
  - Required: req_ready[0] one cycle later; uart_en pulses once; uart_din=8'h55 for the whole busy window; the bench uart_recv yields 8'h55 with uart_done.
- Round-robin:
  - Stimulus: all three requesters held valid with bytes 8'h00/8'h01/8'h02.
  - Required: the receiver sees the order 00,01,02,00,01,02; grant_id sequence 0,1,2,0,1,2.
- Back-pressure:
  - Stimulus: requester 1 asserts valid while a byte is in WAIT_DONE.
  - Required: req_ready[1] only after busy falls; no second uart_en while busy=1.
- Timeout:
  - Stimulus: tie uart_tx_busy=0 and request a byte.
  - Required: after BUSY_TIMEOUT=64 cycles, tx_err=1 and state returns to IDLE; the next request is still served; tx_err stays 1 until sys_rst.
- Reset mid-operation:
  - Stimulus: assert sys_rst for one cycle during WAIT_DONE.
  - Required: all outputs return to reset values on the next edge and the pointer returns to 0.
- Lock (UART_ARB_LOCK_EN defined):
  - Stimulus: requester 2 sends 8'hA0, 8'hA1, 8'hA2 with req_lock=1 for the first two bytes while requester 0 is continuously valid.
  - Required: A0,A1,A2 are sent contiguously, then requester 0's byte. Without the macro, requester 0's byte is interleaved after A0.
